// File: rtl/ahfp_pkg.sv
// ahfp_pkg: shared constants and types for the ahfp floating-point blocks.
// Format: sign[31], exponent[30:23] (bias 127), mantissa[22:0] with hidden 1.
// No denormals; exponent 0 means zero.
package ahfp_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned BIAS  = 127;

  localparam logic [31:0] MAX_FINITE = 32'h7F7F_FFFF;
  localparam logic [31:0] POS_INF    = 32'h7F80_0000;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    READ  = 2'd1,
    CLEAR = 2'd2,
    SUB   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE1
  } state_e;

  // Unpacked operand: 24-bit mantissa includes the hidden bit.
  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W:0]   m;
  } unp_t;

  // exp==0 is zero (mantissa forced 0); exp==255 is clamped to max finite.
  function automatic unp_t unpack(input logic [31:0] x);
    unp_t u;
    u.s = x[31];
    if (x[30:23] == '0) begin
      u.e = '0;
      u.m = '0;
    end else if (x[30:23] == '1) begin
      u.e = 8'd254;
      u.m = '1;
    end else begin
      u.e = x[30:23];
      u.m = {1'b1, x[22:0]};
    end
    return u;
  endfunction

endpackage

// File: rtl/ahfp_align_shift.sv
// ahfp_align_shift: combinational 24-bit right barrel shifter used to align
// the smaller operand. Shift amounts >= 24 clear the result.
// Ports:
//   i_mant  [23:0] mantissa to shift
//   i_shamt [7:0]  right-shift amount (exponent difference)
//   o_mant  [23:0] shifted mantissa, shifted-out bits discarded
module ahfp_align_shift (
  input  logic [23:0] i_mant,
  input  logic [7:0]  i_shamt,
  output logic [23:0] o_mant
);

  always_comb begin
    o_mant = '0;
    if (i_shamt < 8'd24) begin
      o_mant = i_mant >> i_shamt;
    end
  end

endmodule

// File: rtl/ahfp_acc.sv
// ahfp_acc: multi-cycle Nios II custom-instruction floating-point
// accumulator. Adds (ACC) or subtracts (SUB) dataa into an internal
// accumulator, READs it, or CLEARs it (returning the old value).
// Optional feature macro: AHFP_ACC_FLAGS_EN adds sticky flags output.
// Parameter:
//   SAT_ON_OVF  1: overflow saturates to +/-max finite, 0: +/-infinity
// Ports:
//   clk     system clock
//   reset   synchronous active-high reset
//   clk_en  clock enable; low holds all state
//   start   command strobe, sampled only in IDLE
//   n[1:0]  opcode: 0 ACC, 1 READ, 2 CLEAR, 3 SUB
//   dataa   32-bit operand
//   done    one-cycle completion pulse
//   result  command result, held until next done
//   flags   (AHFP_ACC_FLAGS_EN only) bit0 sticky overflow, bit1 sticky flush
module ahfp_acc
  import ahfp_pkg::*;
#(
  parameter int SAT_ON_OVF = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result
`ifdef AHFP_ACC_FLAGS_EN
  ,
  output logic [1:0]  flags
`endif
);

  state_e      r_state;
  op_e         r_op;
  logic [31:0] r_acc;
  logic [31:0] r_result;
  logic        r_done;
  unp_t        r_a;
  unp_t        r_b;
  logic [23:0] r_ml;
  logic [23:0] r_ms;
  logic [7:0]  r_el;
  logic        r_sl;
  logic        r_diff;
  logic [24:0] r_sum;
  logic [7:0]  r_exp;

  // Magnitude ordering and alignment of the smaller operand.
  logic        w_a_big;
  logic [7:0]  w_el;
  logic [7:0]  w_es;
  logic [23:0] w_ms_raw;
  logic [23:0] w_ms_shift;

  assign w_a_big  = {r_a.e, r_a.m} >= {r_b.e, r_b.m};
  assign w_el     = w_a_big ? r_a.e : r_b.e;
  assign w_es     = w_a_big ? r_b.e : r_a.e;
  assign w_ms_raw = w_a_big ? r_b.m : r_a.m;

  ahfp_align_shift u_shift (
    .i_mant  (w_ms_raw),
    .i_shamt (w_el - w_es),
    .o_mant  (w_ms_shift)
  );

  // Normalisation finish decode: one decision per NORM cycle.
  logic        w_ovf;
  logic        w_unf;
  logic        w_fin;
  logic [31:0] w_val;
  logic [31:0] w_ovf_val;

  assign w_ovf_val = (SAT_ON_OVF != 0) ? {r_sl, MAX_FINITE[30:0]}
                                       : {r_sl, POS_INF[30:0]};
  assign w_ovf = (r_state == NORM) && r_sum[24] && (r_exp == 8'd254);
  assign w_unf = (r_state == NORM) && (r_sum[24:23] == 2'b00) &&
                 (r_sum != '0) && (r_exp == 8'd1);

  always_comb begin
    w_fin = 1'b0;
    w_val = '0;
    if (r_state == NORM) begin
      if (r_sum == '0) begin
        w_fin = 1'b1;                     // exact cancellation -> +0
      end else if (w_ovf) begin
        w_fin = 1'b1;
        w_val = w_ovf_val;
      end else if (r_sum[24]) begin
        w_fin = 1'b1;
        w_val = {r_sl, r_exp + 8'd1, r_sum[23:1]};
      end else if (r_sum[23]) begin
        w_fin = 1'b1;
        w_val = {r_sl, r_exp, r_sum[22:0]};
      end else if (w_unf) begin
        w_fin = 1'b1;
        w_val = {r_sl, 31'd0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_op     <= ACC;
      r_acc    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_ml     <= '0;
      r_ms     <= '0;
      r_el     <= '0;
      r_sl     <= 1'b0;
      r_diff   <= 1'b0;
      r_sum    <= '0;
      r_exp    <= '0;
    end else if (clk_en) begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op <= op_e'(n);
            r_a  <= unpack(r_acc);
            // SUB is ACC with the operand sign flipped at latch time.
            r_b  <= unpack({dataa[31] ^ (n == SUB), dataa[30:0]});
            if (n == READ || n == CLEAR) r_state <= DONE1;
            else                         r_state <= ALIGN;
          end
        end
        DONE1: begin
          r_result <= r_acc;
          r_done   <= 1'b1;
          if (r_op == CLEAR) r_acc <= '0;
          r_state  <= IDLE;
        end
        ALIGN: begin
          r_ml    <= w_a_big ? r_a.m : r_b.m;
          r_ms    <= w_ms_shift;
          r_el    <= w_el;
          r_sl    <= w_a_big ? r_a.s : r_b.s;
          r_diff  <= r_a.s ^ r_b.s;
          r_state <= ADD;
        end
        ADD: begin
          r_sum   <= r_diff ? ({1'b0, r_ml} - {1'b0, r_ms})
                            : ({1'b0, r_ml} + {1'b0, r_ms});
          r_exp   <= r_el;
          r_state <= NORM;
        end
        NORM: begin
          if (w_fin) begin
            r_acc    <= w_val;
            r_result <= w_val;
            r_done   <= 1'b1;
            r_state  <= IDLE;
          end else begin
            r_sum <= {r_sum[23:0], 1'b0};
            r_exp <= r_exp - 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign done   = r_done;
  assign result = r_result;

`ifdef AHFP_ACC_FLAGS_EN
  logic [1:0] r_flags;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= '0;
    end else if (clk_en) begin
      if (r_state == DONE1 && r_op == CLEAR) begin
        r_flags <= '0;
      end else if (w_fin) begin
        r_flags <= r_flags | {w_unf, w_ovf};
      end
    end
  end

  assign flags = r_flags;
`endif

endmodule
